// File: rtl/dsp_pkg.sv
// dsp_pkg: shared sample width and detector FSM state encoding for the filter/detector blocks
package dsp_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMING    = 2'd1,
        ST_ACTIVE    = 2'd2,
        ST_RELEASING = 2'd3
    } det_state_t;

    function automatic logic is_detecting(input det_state_t s);
        return (s == ST_ACTIVE) || (s == ST_RELEASING);
    endfunction

endpackage

// File: rtl/fs_edge_sync.sv
// fs_edge_sync: two-flop synchroniser for the f_s sample clock with a falling-edge strobe
module fs_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic f_s,
    output logic strobe
);

    logic pl0, pl1;

    // bring f_s into the clk domain; pl1 is the older sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pl0 <= 1'b0;
            pl1 <= 1'b0;
        end else begin
            pl0 <= f_s;
            pl1 <= pl0;
        end
    end

    assign strobe = pl1 & ~pl0;

endmodule

// File: rtl/iir_env_detect.sv
// iir_env_detect: rectifier, attack/release envelope follower and hysteretic tone-present flag
module iir_env_detect
    import dsp_pkg::*;
#(
    parameter int              W_IN      = SAMPLE_W,
    parameter int              ATK_SHIFT = 2,
    parameter int              REL_SHIFT = 6,
    parameter logic [W_IN-1:0] TH_ON     = W_IN'(4096),
    parameter logic [W_IN-1:0] TH_OFF    = W_IN'(2048),
    parameter int              HOLD_N    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   f_s,
    input  logic signed [W_IN-1:0] din,
    output logic        [W_IN-1:0] env,
    output logic                   env_valid,
    output logic                   detect,
    output logic        [1:0]      state
);

    localparam logic [W_IN-1:0] A_MAX = {1'b0, {(W_IN-1){1'b1}}};
    localparam logic [W_IN:0]   ONE   = (W_IN+1)'(1);

    logic                   s0, v1, v2, v3;
    logic signed [W_IN-1:0] x;
    logic        [W_IN-1:0] x_neg, a_nxt, a, env_acc, env_nxt;
    logic        [W_IN:0]   up, dn, du, dd, sum, dif;
    det_state_t             st, st_nxt;
    logic        [3:0]      cnt, cnt_nxt, cnt_inc;
    logic                   on, off, hit;

    fs_edge_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .f_s    (f_s),
        .strobe (s0)
    );

    // full-wave rectify; only -max-1 negates to a value with the MSB set, so clamp it
    always_comb begin
        x_neg = -x;
        a_nxt = !x[W_IN-1] ? $unsigned(x) : (x_neg[W_IN-1] ? A_MAX : x_neg);
    end

    // one-pole follower: step toward a by a shifted error, at least 1 LSB, never past a
    always_comb begin
        up      = {1'b0, a} - {1'b0, env_acc};
        dn      = {1'b0, env_acc} - {1'b0, a};
        du      = up >> ATK_SHIFT;
        dd      = dn >> REL_SHIFT;
        sum     = {1'b0, env_acc} + ((du == '0) ? ONE : du);
        dif     = {1'b0, env_acc} - ((dd == '0) ? ONE : dd);
        env_nxt = (a > env_acc) ? (sum[W_IN] ? A_MAX : sum[W_IN-1:0]) :
                  (a < env_acc) ? (dif[W_IN] ? '0 : dif[W_IN-1:0]) : env_acc;
    end

    // capture, rectify and envelope stages plus the output strobe; each stage runs independently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            env_valid <= 1'b0;
            x         <= '0;
            a         <= '0;
            env_acc   <= '0;
            env       <= '0;
        end else begin
            v1        <= s0;
            v2        <= v1;
            v3        <= v2;
            env_valid <= v3;
            if (s0) x <= din;
            if (v1) a <= a_nxt;
            if (v2) env_acc <= env_nxt;
            if (v3) env <= env_acc;
        end
    end

    // hysteresis decisions use the freshly updated envelope; cnt counts consecutive qualifying samples
    always_comb begin
        on      = env_acc >= TH_ON;
        off     = env_acc < TH_OFF;
        cnt_inc = cnt + 4'd1;
        hit     = cnt_inc >= 4'(HOLD_N);
        st_nxt  = st;
        cnt_nxt = cnt;
        unique case (st)
            ST_IDLE, ST_ARMING: begin
                st_nxt  = !on ? ST_IDLE : (hit ? ST_ACTIVE : ST_ARMING);
                cnt_nxt = (on && !hit) ? cnt_inc : 4'd0;
            end
            default: begin
                st_nxt  = !off ? ST_ACTIVE : (hit ? ST_IDLE : ST_RELEASING);
                cnt_nxt = (off && !hit) ? cnt_inc : 4'd0;
            end
        endcase
    end

    // FSM advances only alongside the env_valid pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st  <= ST_IDLE;
            cnt <= 4'd0;
        end else if (v3) begin
            st  <= st_nxt;
            cnt <= cnt_nxt;
        end
    end

    assign state  = st;
    assign detect = is_detecting(st);

endmodule

// File: tb/tb_iir_env_detect.sv
// tb_iir_env_detect: randomized scoreboard bench against a behavioural envelope/hysteresis model
module tb_iir_env_detect;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               f_s = 1'b0;
    logic signed [15:0] din = '0;
    logic        [15:0] env;
    logic               env_valid, detect;
    logic        [1:0]  state;

    iir_env_detect dut (
        .clk       (clk),
        .rst       (rst),
        .f_s       (f_s),
        .din       (din),
        .env       (env),
        .env_valid (env_valid),
        .detect    (detect),
        .state     (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int env;
        int det;
        int st;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;
    int   m_env = 0;
    int   m_run = 0;
    int   m_det = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // behavioural model: envelope follower on plain integers, then a run counter that flips
    // the detect flag after 4 consecutive samples beyond the relevant threshold
    task automatic model_step(input int v, output exp_t r);
        int a, d, q_ok;
        a = (v < 0) ? -v : v;
        if (a > 32767) a = 32767;
        if (a > m_env) begin
            d = (a - m_env) / 4;
            m_env += (d < 1) ? 1 : d;
        end else if (a < m_env) begin
            d = (m_env - a) / 64;
            m_env -= (d < 1) ? 1 : d;
        end
        q_ok  = m_det ? (m_env < 2048) : (m_env >= 4096);
        m_run = q_ok ? m_run + 1 : 0;
        if (m_run >= 4) begin
            m_det = !m_det;
            m_run = 0;
        end
        r.env = m_env;
        r.det = m_det;
        r.st  = m_det ? ((m_run > 0) ? 3 : 2) : ((m_run > 0) ? 1 : 0);
    endtask

    // one f_s period: falling edge just after a clk edge, result expected 5 clk later
    task automatic send(input int v);
        exp_t r;
        @(posedge clk);
        #1;
        din = 16'(v);
        f_s = 1'b0;
        model_step(v, r);
        r.cyc = cyc + 5;
        q.push_back(r);
        repeat (6) @(posedge clk);
        #1 f_s = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    // monitor: every env_valid pulse is matched against the oldest expected result
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc < cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL missing env_valid: expected at cycle %0d, now %0d", q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if (env_valid) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected env_valid: got 1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("latency", cyc, e.cyc);
                chk("env", env, e.env);
                chk("detect", detect, e.det);
                chk("state", state, e.st);
                chk("env_msb", env[15], 0);
            end
        end
    end

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_env", env, 0);
        chk("rst_valid", env_valid, 0);
        chk("rst_detect", detect, 0);
        chk("rst_state", state, 0);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1 f_s = 1'b1;
        repeat (10) @(posedge clk);
        chk("idle_env", env, 0);
        chk("idle_state", state, 0);

        repeat (8) send(16000);
        chk("attack_detect", detect, 1);

        repeat (60) send(-32768);
        chk("sat_env", env, 32767);

        for (int i = 0; i < 300 && !(m_det && m_run >= 2); i++) send(0);
        chk("rel_glitch_enter", state, 3);
        repeat (3) send(20000);
        chk("rel_glitch_detect", detect, 1);
        chk("rel_glitch_state", state, 2);

        for (int i = 0; i < 400 && m_det; i++) send(0);
        chk("release_detect", detect, 0);
        chk("release_state", state, 0);

        for (int i = 0; i < 60 && !(!m_det && m_run == 3); i++) send(4150);
        chk("arm_glitch_enter", state, 1);
        send(0);
        chk("arm_glitch_state", state, 0);
        chk("arm_glitch_detect", detect, 0);

        for (int b = 0; b < 6; b++) begin
            int amp;
            amp = $urandom_range(0, 32767);
            for (int i = 0; i < 25; i++) begin
                int v;
                v = $urandom_range(0, amp);
                send($urandom_range(0, 1) ? -v : v);
            end
        end

        for (int i = 0; i < 20 && m_env < 9000; i++) send(16000);
        @(posedge clk);
        #1;
        din = 16'sd16000;
        f_s = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_env", env, 0);
        chk("midrst_valid", env_valid, 0);
        chk("midrst_detect", detect, 0);
        chk("midrst_state", state, 0);
        q.delete();
        m_env = 0;
        m_run = 0;
        m_det = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1 f_s = 1'b1;
        repeat (5) @(posedge clk);
        repeat (3) send(16000);
        chk("restart_env", env, 9250);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending results, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iir_env_detect.md
Name: iir_env_detect

Overview:
Downstream stage that consumes the signed 16-bit output of the IIR band-pass filter, one sample per f_s period. It resynchronises the f_s sample clock and captures din on each f_s falling edge. It then full-wave rectifies the sample, runs an attack/release one-pole envelope follower and drives a hysteretic tone-present flag. Typical use is detecting whether a tone falls inside the BPF passband.

Parameters:
W_IN, 16, din width (signed)
ATK_SHIFT, 2, attack coefficient = 2^-ATK_SHIFT
REL_SHIFT, 6, release coefficient = 2^-REL_SHIFT
TH_ON, 16'd4096, env level that arms detection (env >= TH_ON)
TH_OFF, 16'd2048, env level that releases detection (env < TH_OFF); must satisfy TH_OFF < TH_ON
HOLD_N, 4, number of consecutive qualifying samples needed to change detect (1..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
f_s  in  1  sample clock, asynchronous to clk; period must be >= 8 clk
din  in  16  signed sample from the BPF output
env  out  16  unsigned envelope, range 0..32767 (MSB always 0)
env_valid  out  1  one-clk pulse when env and detect are updated
detect  out  1  tone-present flag
state  out  2  FSM state for debug: 0 IDLE, 1 ARMING, 2 ACTIVE, 3 RELEASING

Behaviour:
- Reset (async, rst=1): all outputs 0; sync flops, pipeline registers, hold counter and FSM cleared; FSM goes to IDLE. Reset mid-operation discards any in-flight sample; env restarts from 0.
- Strobe generation: two-flop synchroniser pl0 <= f_s, pl1 <= pl0. Strobe s0 = pl1 & ~pl0, i.e. the f_s falling edge. A rising edge never triggers.
- Pipeline, one stage per clk:
  - S0: on s0, capture x = din.
  - S1: a = |x|, saturating, so -32768 maps to 32767.
  - S2: envelope update.
  - S3: FSM update; env_valid pulses.
- Latency: env_valid is high exactly 3 clk after the s0 cycle.
- Envelope update in S2:
  - If a > env: d = (a - env) >> ATK_SHIFT, env += max(d, 1).
  - If a < env: d = (env - a) >> REL_SHIFT, env -= max(d, 1).
  - If a == env: hold.
  - Compute in 17 bits. env never overshoots a and never leaves 0..32767.
- FSM, evaluated only in S3, using the new env; cnt is a 4-bit counter:
  - IDLE: env >= TH_ON -> ARMING, cnt = 1. If HOLD_N == 1, go straight to ACTIVE.
  - ARMING: env >= TH_ON -> cnt++; when cnt reaches HOLD_N -> ACTIVE. Otherwise (env < TH_ON) -> IDLE, cnt = 0.
  - ACTIVE: detect = 1. env < TH_OFF -> RELEASING, cnt = 1 (same HOLD_N == 1 shortcut, to IDLE).
  - RELEASING: detect stays 1. env < TH_OFF -> cnt++; when cnt reaches HOLD_N -> IDLE, detect = 0. Otherwise (env >= TH_OFF) -> ACTIVE, cnt = 0.
- detect and state change only in the env_valid cycle.
- Overlap: a new s0 cannot arrive while the pipeline is busy, given the f_s period constraint. If it does, the new sample is accepted; stages are independent registers and no stall is required.
- din is sampled only in the S0 cycle. It may change at any other time.

Decomposition:
- Shared package (dsp_pkg): FSM state encoding constants (IDLE..RELEASING) and the 16-bit sample width constant, reused by other filter/detector blocks.
- One natural sub-module: fs_edge_sync (two-flop synchroniser plus falling-edge strobe), reusable by every f_s-driven stage.
- Envelope arithmetic and FSM stay inline.

Test Plan:
1. Reset then hold f_s low -> env=0, env_valid never pulses, detect=0, state=0. Assert rst mid-run with env≈9000 -> all outputs 0 within the same clk.
2. Edge/latency: toggle f_s with din=16000 -> env_valid rises exactly 5 clk after the f_s falling edge (2 sync + 3 pipe). No pulse occurs on the rising edge. First env=4000.
3. Attack/arm: env from 0, din=16000 constant -> env sequence 4000, 7000, 9250. detect rises at the env_valid of the 5th sample, with state sequence 0, 1, 1, 1, 2.
4. Saturation: din=-32768 repeatedly -> a=32767; env converges to exactly 32767, never wraps, MSB stays 0.
5. Release/hysteresis: from ACTIVE with env≈16000, set din=0 -> env decays by max(env>>6, 1) per sample. detect stays 1 until env < 2048 for 4 consecutive samples (≈130–136 samples), then goes to 0 and state 0. Check cycle-exact against the reference model.
6. Glitch rejection:
   - In ARMING, 3 samples >= TH_ON then 1 below -> back to IDLE, detect=0.
   - In RELEASING, env back above TH_OFF -> ACTIVE, detect held at 1 throughout.
